// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller command port among several requesters.
// It runs one command at a time, routes read data to the port that issued the read, and latches a sticky fault flag.
module sdram_arbiter #(
    parameter int Ports       = 2,
    parameter int AddrWidth   = 23,
    parameter int DataWidth   = 16,
    parameter int BusyTimeout = 255
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [Ports-1:0]           req_trigger,
    output logic [Ports-1:0]           req_ready,
    input  logic [Ports*AddrWidth-1:0] req_addr,
    input  logic [Ports-1:0]           req_write,
    input  logic [Ports*DataWidth-1:0] req_writeData,
    output logic [DataWidth-1:0]       req_readData,
    output logic [Ports-1:0]           req_readDataValid,
    input  logic                       cmdReady,
    output logic                       cmdTrigger,
    output logic [AddrWidth-1:0]       cmdAddr,
    output logic                       cmdWrite,
    output logic [DataWidth-1:0]       cmdWriteData,
    input  logic [DataWidth-1:0]       cmdReadData,
    input  logic                       cmdReadDataValid,
    output logic                       err,
    output logic [1:0]                 o_dbg_state
);

    localparam int OwnerW = $clog2(Ports);
    localparam int CountW = $clog2(BusyTimeout + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    localparam logic [OwnerW-1:0] LastInit = OwnerW'(Ports - 1);
    localparam logic [CountW-1:0] CountMax = CountW'(BusyTimeout);

    logic [1:0]           r_state;
    logic [OwnerW-1:0]    r_owner;
    logic [OwnerW-1:0]    r_last;
    logic [CountW-1:0]    r_busy_count;
    logic                 r_err;
    logic                 r_cmd_trigger;
    logic [AddrWidth-1:0] r_cmd_addr;
    logic                 r_cmd_write;
    logic [DataWidth-1:0] r_cmd_write_data;

    logic [OwnerW-1:0]    w_grant;
    logic [OwnerW-1:0]    w_idx;
    logic                 w_grant_vld;
    logic                 w_accept;
    logic [CountW-1:0]    w_count_next;

    // Scan from the far end back toward last+1 so the closest requester wins.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_idx       = '0;
        for (int k = Ports; k >= 1; k--) begin
            w_idx = OwnerW'((int'(r_last) + k) % Ports);
            if (req_trigger[w_idx]) begin
                w_grant     = w_idx;
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_accept     = rst_ && (r_state == IDLE) && cmdReady && w_grant_vld;
    assign w_count_next = r_busy_count + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        req_readDataValid = '0;
        if (rst_ && cmdReadDataValid && (r_state != IDLE) && !r_cmd_write) begin
            req_readDataValid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state          <= IDLE;
            r_owner          <= '0;
            r_last           <= LastInit;
            r_busy_count     <= '0;
            r_err            <= 1'b0;
            r_cmd_trigger    <= 1'b0;
            r_cmd_addr       <= '0;
            r_cmd_write      <= 1'b0;
            r_cmd_write_data <= '0;
        end else begin
            r_cmd_trigger <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmdReadDataValid) begin
                        r_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_cmd_addr       <= req_addr[w_grant*AddrWidth +: AddrWidth];
                        r_cmd_write      <= req_write[w_grant];
                        r_cmd_write_data <= req_writeData[w_grant*DataWidth +: DataWidth];
                        r_owner          <= w_grant;
                        r_last           <= w_grant;
                        r_cmd_trigger    <= 1'b1;
                        r_state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_busy_count <= '0;
                    r_state      <= BUSY;
                end
                BUSY: begin
                    r_busy_count <= w_count_next;
                    // A ready controller wins over a timeout that expires in the same cycle.
                    if (cmdReady) begin
                        r_state <= IDLE;
                    end else if (w_count_next == CountMax) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if ((r_state != IDLE) && r_cmd_write && cmdReadDataValid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmdTrigger   = r_cmd_trigger;
    assign cmdAddr      = r_cmd_addr;
    assign cmdWrite     = r_cmd_write;
    assign cmdWriteData = r_cmd_write_data;
    assign req_readData = cmdReadData;
    assign err          = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single SDRAM controller command port among `Ports` requesters.
- Each requester has its own valid/ready command channel.
- The block sequences exactly one command at a time into the controller's `cmdTrigger` interface.
- Read data is routed back to the requester that issued the read.
- Sits between client blocks (pixel capture, host readout) and the SDRAM controller. It also flags protocol faults (hung controller, stray read data).

## Interface
- `Ports`, default 2: number of requesters, 2..8.
- `AddrWidth`, default 23: SDRAM word address width (bank, row, col).
- `DataWidth`, default 16: data word width.
- `BusyTimeout`, default 255: max cycles in Busy before fault.
- `clk` in 1: single clock, all logic on posedge.
- `rst_` in 1: reset, synchronous, active-low.
- `req_trigger` in Ports: request valid, one bit per port.
- `req_ready` out Ports: accept. A command is accepted when `req_trigger[i] && req_ready[i]`.
- `req_addr` in Ports*AddrWidth: port i at `[i*AddrWidth +: AddrWidth]`.
- `req_write` in Ports: 1 = write, 0 = read.
- `req_writeData` in Ports*DataWidth: port i at `[i*DataWidth +: DataWidth]`.
- `req_readData` out DataWidth: equals `cmdReadData`, broadcast to all ports.
- `req_readDataValid` out Ports: read word valid for the owning port.
- `cmdReady` in 1: controller idle.
- `cmdTrigger` out 1: one-cycle command strobe.
- `cmdAddr` out AddrWidth: latched address.
- `cmdWrite` out 1: latched direction.
- `cmdWriteData` out DataWidth: latched write data.
- `cmdReadData` in DataWidth: controller read word.
- `cmdReadDataValid` in 1: controller read word valid.
- `err` out 1: sticky fault flag; cleared only by reset.

## Operation
- States: Idle, Issue, Busy.
- Registers:
  - `state`
  - `owner` [$clog2(Ports)]
  - `last` (last granted port)
  - latched `cmdAddr`/`cmdWrite`/`cmdWriteData`
  - `busyCount` [$clog2(BusyTimeout+1)]
  - `err`
- Grant, combinational: the first port i with `req_trigger[i]`, scanning `last+1, last+2, …` modulo `Ports`.
- `req_ready[i]` = (state==Idle) && `cmdReady` && (grant==i), combinational. At most one bit is high.
- **Idle**
  - On accept: latch the owner's addr/write/data into the `cmd*` registers; `owner` <= grant; `last` <= grant; → Issue.
  - `cmdReadDataValid` seen in Idle sets `err`; the word is dropped.
- **Issue**
  - `cmdTrigger`=1 for exactly this cycle; `busyCount` <= 0; → Busy.
- **Busy**
  - `busyCount` increments each cycle.
  - Exit to Idle on the first cycle `cmdReady`==1.
  - If `busyCount` reaches `BusyTimeout` first: `err` <= 1, → Idle (command abandoned).
- Read routing: `req_readDataValid[i]` = `cmdReadDataValid` && (state!=Idle) && !`cmdWrite` && (owner==i).
- `cmdReadDataValid` during a write command (state!=Idle && `cmdWrite`) sets `err`; it is not routed.
- Requester rules:
  - A requester holds addr/write/data stable while `req_trigger` is high and not yet accepted.
  - Dropping `req_trigger` before accept is legal and creates no obligation.
- Fairness: a continuously requesting port is granted within `Ports`-1 other grants.
- Reset (`rst_`==0 at posedge) takes effect even mid-command:
  - state=Idle, owner=0, `last`=Ports-1 (port 0 has first priority), `busyCount`=0, `err`=0.
  - `cmdTrigger`=0, `cmdAddr`=0, `cmdWrite`=0, `cmdWriteData`=0.
  - `req_readDataValid`=0 and `req_ready`=0 while in reset.

## Timing
- Accept at cycle T → `cmdTrigger`=1 at T+1 with latched fields → Busy from T+2.
- `cmd*` fields hold their values until the next accept; only `cmdTrigger` pulses.
- Busy→Idle on the edge after `cmdReady` is sampled high. A new accept is possible in the first Idle cycle.
- Minimum command period is 4 cycles, for a controller that drops `cmdReady` for 1 cycle: Issue, Busy(ready=0), Busy(ready=1), Idle/accept.
- No `cmdTrigger` is issued unless `cmdReady` was high at the accept cycle.
- `cmdTrigger` is never asserted in two consecutive cycles.
- `req_readDataValid` has zero latency: it follows `cmdReadDataValid` in the same cycle.

## Test plan
- Reset: hold `rst_`=0 for 2 cycles with all triggers high → `cmdTrigger`=0, `req_ready`=0, `err`=0; after release, port 0 is accepted first.
- Contention, Ports=2, both triggers held, model drops `cmdReady` 3 cycles after each trigger → grants alternate 0,1,0,1; 4 commands issue with `cmdAddr` 0x000010, 0x400020, 0x000010, 0x400020 from those port addresses.
- Read routing: port 1 reads 0x123456; model returns 0xBEEF with `cmdReadDataValid` 3 cycles after trigger → `req_readDataValid`=2'b10 for exactly 1 cycle, `req_readData`=0xBEEF, `err`=0.
- Timeout: BusyTimeout=8, model holds `cmdReady`=0 after trigger → `err`=1 after 8 Busy cycles, state returns to Idle, and the next request is accepted once `cmdReady`=1.
- Stray data: pulse `cmdReadDataValid` while Idle, and again during a write → `err`=1, `req_readDataValid` stays 0.
- Mid-command reset: `rst_`=0 during Busy of a read → next cycle `cmdTrigger`=0, `err`=0, and `cmdReadDataValid` arriving afterwards in Idle sets `err`.
